// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes a WIDTH-bit word over valid/ready and shifts it out
// one bit per clock on a registered output, reloading on the last bit for gap-free streaming.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sout_q, sout_d;
    logic              frame_q, frame_d;
    logic              last_bit;
    logic              xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sout_d   = 1'b0;
        frame_d  = 1'b0;

        last_bit = (state_q == StShift) && (cnt_q == '0);
        // Gated by rst_n so ready drops the instant reset asserts.
        din_ready = rst_n && ((state_q == StIdle) || last_bit);
        xfer      = din_valid && din_ready;

        if (xfer) begin
            state_d = StShift;
            shreg_d = din;
            cnt_d   = CntW'(WIDTH - 1);
            sout_d  = LSB_FIRST ? din[0] : din[WIDTH-1];
            frame_d = 1'b1;
        end else if (state_q == StShift) begin
            if (last_bit) begin
                state_d = StIdle;
                shreg_d = '0;
            end else begin
                // The register keeps the bit currently on sout at the shift end, so the
                // next bit is the one that lands there after this shift.
                if (LSB_FIRST) begin
                    shreg_d = shreg_q >> 1;
                    sout_d  = shreg_d[0];
                end else begin
                    shreg_d = shreg_q << 1;
                    sout_d  = shreg_d[WIDTH-1];
                end
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    assign sout        = sout_q;
    assign sout_valid  = (state_q == StShift);
    assign busy        = (state_q == StShift);
    assign frame_start = frame_q;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage on the transmit side of the SerDes.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock.
- Its registered serial output feeds the downstream bit-level flop stage.
- Back-to-back words stream with no idle gap, so the line runs at full bit rate.

Parameters:
WIDTH, 8, parallel word width in bits (≥2)
LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit WIDTH-1 first

Ports:
clk  input  1  bit clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a word to transmit
din_ready  output  1  block can accept a word this cycle
sout  output  1  serial data bit, registered
sout_valid  output  1  sout carries a real data bit this cycle
frame_start  output  1  high on the cycle sout carries the first bit of a word
busy  output  1  a word is being shifted out

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0: sout=0, sout_valid=0, frame_start=0, busy=0, din_ready=0, shift register=0, bit counter=0, FSM=IDLE.
  - din_ready rises combinationally once rst_n=1 and FSM=IDLE.
- Handshake:
  - A transfer occurs on a rising edge where din_valid=1 and din_ready=1.
  - din is sampled only on that edge.
  - din_valid=1 with din_ready=0 is a stall: the word is held by the source, not dropped.
- FSM state IDLE:
  - din_ready=1.
  - On transfer: load shift register with din, counter=WIDTH-1, go to SHIFT.
  - Outputs in the cycle after the load edge: sout=first bit, sout_valid=1, frame_start=1.
- FSM state SHIFT:
  - Each edge presents the next bit, decrementing the counter.
  - din_ready=1 only when counter==0, i.e. the last bit is on sout.
  - Last-bit edge with a transfer: reload directly, stay in SHIFT, frame_start=1 next cycle (zero-gap streaming).
  - Last-bit edge without a transfer: go to IDLE; next cycle sout=0, sout_valid=0.
- Latency: accept edge N → bit 0 of the word on sout during cycle N+1 → last bit during cycle N+WIDTH.
- Bit order:
  - LSB_FIRST=1: din[0], din[1] … din[WIDTH-1].
  - LSB_FIRST=0: reversed.
- busy=1 exactly while sout_valid=1.
- frame_start is high for exactly one cycle per word and never when sout_valid=0.
- Idle line: sout held 0.
- Counter width: clog2(WIDTH). No wrap beyond WIDTH-1; the counter only reloads on a transfer.
- Reset mid-word: the frame is abandoned immediately (asynchronously). After release the block starts in IDLE with no residual bits emitted.
- din changing without a transfer has no effect on sout.

Test Plan:
- Reset → outputs zero. Assert rst_n=0 mid-cycle with din_valid=1 → sout, sout_valid, busy, din_ready all 0 without waiting for a clk edge. Release → din_ready=1 in IDLE.
- Single word, WIDTH=8, LSB_FIRST=1: din=8'hA5 accepted at edge 0.
  - Cycles 1-8: sout = 1,0,1,0,0,1,0,1; frame_start=1 only in cycle 1; sout_valid=1 in cycles 1-8.
  - Cycle 9: sout=0, sout_valid=0, din_ready=1.
- Back-to-back: 8'h0F then 8'hF0 with din_valid held high.
  - Second word accepted on the edge ending cycle 8.
  - sout = 1111_0000_0000_1111 over 16 consecutive cycles with no gap; frame_start in cycles 1 and 9 only.
- Stall: din_valid=1 with new word 8'h3C while busy on the 5th bit → din_ready=0 until the last bit. The word is taken then and emitted LSB first starting the next cycle; the earlier word is uncorrupted.
- MSB-first build (LSB_FIRST=0): din=8'h81 → sout = 1,0,0,0,0,0,0,1. Also din=8'hC0 → 1,1,0,0,0,0,0,0.
- Reset after the 3rd bit of 8'hFF → outputs zero immediately. After release with din_valid=0: sout stays 0 and sout_valid stays 0 indefinitely, with no leftover 1s.
